find_star: RTL and testbench
============================

# find_star

Upstream stage of `clean_star`. Raster-scans the frame buffer for the first bright pixel and measures a bounding box around it. It then hands the padded box to `clean_star` via `goClean`, waits for `doneClean`, and resumes scanning. It repeats until the frame contains no bright pixels, counting the stars it finds.

## Interface
- `xSz`, 8, x coordinate width
- `ySz`, 7, y coordinate width
- `colSz`, 3, pixel colour width
- `XMAX`, 159, last valid x column
- `YMAX`, 119, last valid y row
- `BRIGHT_MASK`, 3'b111, a pixel is bright when `(pixIn & BRIGHT_MASK) != 0`
- `PAD`, 2, pixels added on every side of the measured box
- `cntSz`, 8, star counter width
- `clk`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `goFind`  in  1  start-of-search pulse, honoured only in IDLE
- `pixIn`  in  colSz  frame-buffer read data for the address presented the previous cycle
- `rdX`  out  xSz  frame-buffer read column
- `rdY`  out  ySz  frame-buffer read row
- `xLeft`, `xRight`  out  xSz  padded, clamped box columns, to `clean_star`
- `yTop`, `yBottom`  out  ySz  padded, clamped box rows, to `clean_star`
- `goClean`  out  1  one-cycle pulse requesting a clean of the box
- `doneClean`  in  1  one-cycle pulse from `clean_star`
- `starCount`  out  cntSz  stars found since the last `goFind`
- `busy`  out  1  high in every state except IDLE
- `doneFind`  out  1  one-cycle pulse when a full raster completes with no further star

## Operation
States and transitions:
- IDLE: `goFind` -> SCAN_RD. On entry from `goFind`: scan position set to (0,0); `starCount` cleared.
- SCAN_RD: present the scan position.
- SCAN_CHK, pixel bright:
  - Latch seed (xs,ys).
  - Set run position to (xs+1, ys).
  - Go to RUNX_RD, or straight to MEASX if xs==XMAX.
- SCAN_CHK, pixel dark: advance in raster order (x+1; wrap to x=0, y+1) -> SCAN_RD. At (XMAX,YMAX) -> DONE.
- RUNX_RD/RUNX_CHK: walk right along row ys.
  - First dark pixel at x: xR = x-1 -> MEASX.
  - Bright pixel at XMAX: xR = XMAX -> MEASX.
- MEASX: xc = (xs+xR)>>1 computed in xSz+1 bits; run position set to (xc, ys+1). Go to RUNY_RD, or skip to PADBOX with yB=ys if ys==YMAX.
- RUNY_RD/RUNY_CHK: walk down column xc.
  - First dark pixel at y: yB = y-1 -> PADBOX.
  - Bright pixel at YMAX: yB = YMAX -> PADBOX.
- PADBOX: register box outputs:
  - `xLeft` = xs≥PAD ? xs-PAD : 0
  - `xRight` = min(xR+PAD, XMAX), computed in xSz+1 bits
  - `yTop` = ys≥PAD ? ys-PAD : 0
  - `yBottom` = min(yB+PAD, YMAX), computed in ySz+1 bits
  - `starCount` increments, saturating at all-ones. Go to CLEAN_REQ.
- CLEAN_REQ: `goClean`=1 for exactly this cycle -> CLEAN_WAIT.
- CLEAN_WAIT: hold until `doneClean`.
  - If seed == (XMAX,YMAX) -> DONE.
  - Otherwise scan position = raster successor of the seed -> SCAN_RD.
- DONE: `doneFind`=1 for one cycle -> IDLE.

Boundary and ignore rules:
- `goFind` outside IDLE: ignored.
- `doneClean` outside CLEAN_WAIT: ignored.
- Box outputs hold their values from PADBOX until the next PADBOX, so they are stable throughout cleaning.

## Timing
- Reset values:
  - `rdX`=0, `rdY`=0
  - all box outputs 0
  - `goClean`=0, `doneFind`=0, `busy`=0, `starCount`=0
  - state IDLE
- Reset mid-operation aborts immediately. No `goClean` is issued afterwards; a pending `doneClean` is ignored.
- All outputs are registered.
- Read latency is 1 cycle: the address driven in a *_RD cycle is checked against `pixIn` in the following *_CHK cycle. Each probed pixel costs 2 cycles.
- `goFind` high in cycle N puts `rdX,rdY`=(0,0) in N+1.
- `goClean` rises 2 cycles after the *_CHK cycle that ends the vertical walk.
- `doneClean` in cycle M: the next SCAN_RD is in M+1.
- Empty frame: `doneFind` is asserted 2·(XMAX+1)·(YMAX+1)+1 cycles after `goFind`.

## Structure
- Shared package `star_pkg` holds:
  - `xSz`, `ySz`, `colSz`, `XMAX`, `YMAX`
  - black colour constant
  - state encoding localparams
- The same package is also consumed by `clean_star`.
- One natural sub-module: `bbox_pad_clamp`, a combinational pad-and-clamp of (xs, xR, ys, yB) to box outputs, parameterised by `PAD`, `XMAX`, `YMAX`.
- Everything else lives in one FSM plus a datapath register block.

## Test plan
- All-black frame, `goFind` -> no `goClean`; `doneFind` pulses exactly 38401 cycles after `goFind`; `starCount`=0.
- Single 3×3 bright blob at x 10..12, y 20..22 -> box (8,14,18,24); `goClean` pulses once; after `doneClean` (bench model clears the box) -> `doneFind`, `starCount`=1.
- Blob at x 0..1, y 0..1 -> box clamped to (0,3,0,3).
- Blob at x 158..159, y 118..119 -> box clamped to (156,159,116,119).
- Single bright pixel at (159,119) -> box (157,159,117,119); after `doneClean` -> straight to `doneFind`, with no further reads.
- Two blobs at (5,5) and (100,50) -> two `goClean` pulses in raster order; `starCount`=2.
- `goFind` during CLEAN_WAIT is ignored.
- `reset` asserted mid-RUNX -> next cycle all outputs equal their reset values and `busy`=0.

Source files
------------

// File: rtl/star_pkg.sv
// Shared constants and state encoding for the star finding/cleaning pipeline.
// Used by find_star and by the downstream clean_star stage.
package star_pkg;

  localparam int xSz   = 8;
  localparam int ySz   = 7;
  localparam int colSz = 3;
  localparam int cntSz = 8;
  localparam int XMAX  = 159;
  localparam int YMAX  = 119;
  localparam int PAD   = 2;

  localparam logic [colSz-1:0] BLACK       = '0;
  localparam logic [colSz-1:0] BRIGHT_MASK = 3'b111;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SCAN_RD    = 4'd1,
    SCAN_CHK   = 4'd2,
    RUNX_RD    = 4'd3,
    RUNX_CHK   = 4'd4,
    MEASX      = 4'd5,
    RUNY_RD    = 4'd6,
    RUNY_CHK   = 4'd7,
    PADBOX     = 4'd8,
    CLEAN_REQ  = 4'd9,
    CLEAN_WAIT = 4'd10,
    DONE       = 4'd11
  } state_t;

endpackage

// File: rtl/bbox_pad_clamp.sv
// Combinational pad-and-clamp of a measured star box to the frame limits.
// Right/bottom sums are formed one bit wider so the clamp sees any overflow.
module bbox_pad_clamp #(
  parameter int PAD  = 2,
  parameter int XMAX = 159,
  parameter int YMAX = 119,
  parameter int XW   = 8,
  parameter int YW   = 7
) (
  input  logic [XW-1:0] xs_i,
  input  logic [XW-1:0] xr_i,
  input  logic [YW-1:0] ys_i,
  input  logic [YW-1:0] yb_i,
  output logic [XW-1:0] x_left_o,
  output logic [XW-1:0] x_right_o,
  output logic [YW-1:0] y_top_o,
  output logic [YW-1:0] y_bottom_o
);

  localparam logic [XW:0] PAD_X  = PAD[XW:0];
  localparam logic [YW:0] PAD_Y  = PAD[YW:0];
  localparam logic [XW:0] XMAX_X = XMAX[XW:0];
  localparam logic [YW:0] YMAX_Y = YMAX[YW:0];

  logic [XW:0] xr_pad;
  logic [YW:0] yb_pad;

  always_comb begin
    xr_pad     = {1'b0, xr_i} + PAD_X;
    yb_pad     = {1'b0, yb_i} + PAD_Y;
    x_left_o   = (xs_i >= PAD_X[XW-1:0]) ? xs_i - PAD_X[XW-1:0] : '0;
    y_top_o    = (ys_i >= PAD_Y[YW-1:0]) ? ys_i - PAD_Y[YW-1:0] : '0;
    x_right_o  = (xr_pad > XMAX_X) ? XMAX_X[XW-1:0] : xr_pad[XW-1:0];
    y_bottom_o = (yb_pad > YMAX_Y) ? YMAX_Y[YW-1:0] : yb_pad[YW-1:0];
  end

endmodule

// File: rtl/find_star.sv
// Raster-scans the frame for bright pixels, measures a box around each star,
// hands the padded box to clean_star and resumes after the clean completes.
module find_star
  import star_pkg::*;
#(
  parameter int FRAME_XMAX = XMAX,
  parameter int FRAME_YMAX = YMAX,
  parameter int BOX_PAD    = PAD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             goFind,
  input  logic [colSz-1:0] pixIn,
  output logic [xSz-1:0]   rdX,
  output logic [ySz-1:0]   rdY,
  output logic [xSz-1:0]   xLeft,
  output logic [xSz-1:0]   xRight,
  output logic [ySz-1:0]   yTop,
  output logic [ySz-1:0]   yBottom,
  output logic             goClean,
  input  logic             doneClean,
  output logic [cntSz-1:0] starCount,
  output logic             busy,
  output logic             doneFind,
  output state_t           dbgState
);

  localparam logic [xSz-1:0] XM = FRAME_XMAX[xSz-1:0];
  localparam logic [ySz-1:0] YM = FRAME_YMAX[ySz-1:0];

  state_t state_q, state_d;
  // px/py is the single probe address: scan position or run position.
  logic [xSz-1:0]   px_q, px_d, xs_q, xs_d, xr_q, xr_d;
  logic [ySz-1:0]   py_q, py_d, ys_q, ys_d, yb_q, yb_d;
  logic [xSz-1:0]   xl_q, xl_d, xrb_q, xrb_d;
  logic [ySz-1:0]   yt_q, yt_d, ybb_q, ybb_d;
  logic [cntSz-1:0] cnt_q, cnt_d;
  logic             go_clean_q, go_clean_d, done_find_q, done_find_d, busy_q, busy_d;

  logic             bright;
  logic [xSz:0]     xc_sum;
  logic [xSz-1:0]   pad_xl, pad_xr;
  logic [ySz-1:0]   pad_yt, pad_yb;

  bbox_pad_clamp #(
    .PAD (BOX_PAD),
    .XMAX(FRAME_XMAX),
    .YMAX(FRAME_YMAX),
    .XW  (xSz),
    .YW  (ySz)
  ) u_pad (
    .xs_i      (xs_q),
    .xr_i      (xr_q),
    .ys_i      (ys_q),
    .yb_i      (yb_q),
    .x_left_o  (pad_xl),
    .x_right_o (pad_xr),
    .y_top_o   (pad_yt),
    .y_bottom_o(pad_yb)
  );

  assign bright = (pixIn & BRIGHT_MASK) != BLACK;
  assign xc_sum = {1'b0, xs_q} + {1'b0, xr_q};

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    xr_d    = xr_q;
    yb_d    = yb_q;
    xl_d    = xl_q;
    xrb_d   = xrb_q;
    yt_d    = yt_q;
    ybb_d   = ybb_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (goFind) begin
          state_d = SCAN_RD;
          px_d    = '0;
          py_d    = '0;
          cnt_d   = '0;
        end
      end
      SCAN_RD: state_d = SCAN_CHK;
      SCAN_CHK: begin
        if (bright) begin
          xs_d = px_q;
          ys_d = py_q;
          px_d = px_q + 1'b1;
          if (px_q == XM) begin
            xr_d    = XM;
            state_d = MEASX;
          end else begin
            state_d = RUNX_RD;
          end
        end else if (px_q == XM && py_q == YM) begin
          state_d = DONE;
        end else begin
          state_d = SCAN_RD;
          if (px_q == XM) begin
            px_d = '0;
            py_d = py_q + 1'b1;
          end else begin
            px_d = px_q + 1'b1;
          end
        end
      end
      RUNX_RD: state_d = RUNX_CHK;
      RUNX_CHK: begin
        if (!bright) begin
          xr_d    = px_q - 1'b1;
          state_d = MEASX;
        end else if (px_q == XM) begin
          xr_d    = XM;
          state_d = MEASX;
        end else begin
          px_d    = px_q + 1'b1;
          state_d = RUNX_RD;
        end
      end
      MEASX: begin
        // A seed on the last row has no column to walk; its box is one row tall.
        if (ys_q == YM) begin
          yb_d    = ys_q;
          state_d = PADBOX;
        end else begin
          px_d    = xSz'(xc_sum >> 1);
          py_d    = ys_q + 1'b1;
          state_d = RUNY_RD;
        end
      end
      RUNY_RD: state_d = RUNY_CHK;
      RUNY_CHK: begin
        if (!bright) begin
          yb_d    = py_q - 1'b1;
          state_d = PADBOX;
        end else if (py_q == YM) begin
          yb_d    = YM;
          state_d = PADBOX;
        end else begin
          py_d    = py_q + 1'b1;
          state_d = RUNY_RD;
        end
      end
      PADBOX: begin
        xl_d    = pad_xl;
        xrb_d   = pad_xr;
        yt_d    = pad_yt;
        ybb_d   = pad_yb;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        state_d = CLEAN_REQ;
      end
      CLEAN_REQ: state_d = CLEAN_WAIT;
      CLEAN_WAIT: begin
        if (doneClean) begin
          if (xs_q == XM && ys_q == YM) begin
            state_d = DONE;
          end else begin
            state_d = SCAN_RD;
            if (xs_q == XM) begin
              px_d = '0;
              py_d = ys_q + 1'b1;
            end else begin
              px_d = xs_q + 1'b1;
              py_d = ys_q;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    go_clean_d  = (state_d == CLEAN_REQ);
    done_find_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      px_q        <= '0;
      py_q        <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      xr_q        <= '0;
      yb_q        <= '0;
      xl_q        <= '0;
      xrb_q       <= '0;
      yt_q        <= '0;
      ybb_q       <= '0;
      cnt_q       <= '0;
      go_clean_q  <= 1'b0;
      done_find_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      xr_q        <= xr_d;
      yb_q        <= yb_d;
      xl_q        <= xl_d;
      xrb_q       <= xrb_d;
      yt_q        <= yt_d;
      ybb_q       <= ybb_d;
      cnt_q       <= cnt_d;
      go_clean_q  <= go_clean_d;
      done_find_q <= done_find_d;
      busy_q      <= busy_d;
    end
  end

  assign rdX       = px_q;
  assign rdY       = py_q;
  assign xLeft     = xl_q;
  assign xRight    = xrb_q;
  assign yTop      = yt_q;
  assign yBottom   = ybb_q;
  assign goClean   = go_clean_q;
  assign doneFind  = done_find_q;
  assign busy      = busy_q;
  assign starCount = cnt_q;
  assign dbgState  = state_q;

endmodule

// File: tb/tb_find_star.sv
// Directed bench for find_star: a full-size instance for empty-frame timing
// and a reduced 40x30 instance (same RTL) for the star scenarios.
module tb_find_star;
  import star_pkg::*;

  localparam int SXMAX = 39;
  localparam int SYMAX = 29;
  localparam int SW    = SXMAX + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             b_goFind, b_doneClean, b_goClean, b_busy, b_doneFind;
  logic [colSz-1:0] b_pixIn;
  logic [xSz-1:0]   b_rdX, b_xLeft, b_xRight;
  logic [ySz-1:0]   b_rdY, b_yTop, b_yBottom;
  logic [cntSz-1:0] b_starCount;
  state_t           b_dbgState;

  logic             s_goFind, s_doneClean, s_goClean, s_busy, s_doneFind;
  logic [colSz-1:0] s_pixIn;
  logic [xSz-1:0]   s_rdX, s_xLeft, s_xRight;
  logic [ySz-1:0]   s_rdY, s_yTop, s_yBottom;
  logic [cntSz-1:0] s_starCount;
  state_t           s_dbgState;

  logic [colSz-1:0] frame [0:SW*(SYMAX+1)-1];
  int checks = 0;
  int errors = 0;
  int s_gc_cnt = 0;
  int b_gc_cnt = 0;

  find_star u_big (
    .clk(clk), .reset(reset), .goFind(b_goFind), .pixIn(b_pixIn),
    .rdX(b_rdX), .rdY(b_rdY), .xLeft(b_xLeft), .xRight(b_xRight),
    .yTop(b_yTop), .yBottom(b_yBottom), .goClean(b_goClean),
    .doneClean(b_doneClean), .starCount(b_starCount), .busy(b_busy),
    .doneFind(b_doneFind), .dbgState(b_dbgState)
  );

  find_star #(.FRAME_XMAX(SXMAX), .FRAME_YMAX(SYMAX)) u_small (
    .clk(clk), .reset(reset), .goFind(s_goFind), .pixIn(s_pixIn),
    .rdX(s_rdX), .rdY(s_rdY), .xLeft(s_xLeft), .xRight(s_xRight),
    .yTop(s_yTop), .yBottom(s_yBottom), .goClean(s_goClean),
    .doneClean(s_doneClean), .starCount(s_starCount), .busy(s_busy),
    .doneFind(s_doneFind), .dbgState(s_dbgState)
  );

  function automatic logic [colSz-1:0] pix_at(input logic [xSz-1:0] x, input logic [ySz-1:0] y);
    if (int'(x) <= SXMAX && int'(y) <= SYMAX) return frame[int'(y)*SW + int'(x)];
    return '0;
  endfunction

  // Frame buffer with one cycle of read latency.
  always @(posedge clk) s_pixIn <= pix_at(s_rdX, s_rdY);

  always @(negedge clk) begin
    if (s_goClean === 1'b1) s_gc_cnt++;
    if (b_goClean === 1'b1) b_gc_cnt++;
  end

  task automatic clear_frame();
    for (int i = 0; i < SW*(SYMAX+1); i++) frame[i] = '0;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) frame[y*SW + x] = 3'b101;
  endtask

  task automatic pulse_go_small();
    @(negedge clk);
    s_goFind = 1'b1;
    @(negedge clk);
    s_goFind = 1'b0;
  endtask

  // Model of clean_star: wait for goClean, capture the box, blank it, answer doneClean.
  // Returns in the cycle after doneClean.
  task automatic serve_clean(input bit poke, output logic [xSz-1:0] xl, output logic [xSz-1:0] xr,
                             output logic [ySz-1:0] yt, output logic [ySz-1:0] yb,
                             output logic [cntSz-1:0] cnt, output logic [xSz-1:0] rx,
                             output logic [ySz-1:0] ry, output bit ok);
    ok = 1'b0;
    xl = '0; xr = '0; yt = '0; yb = '0; cnt = '0; rx = '0; ry = '0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (s_goClean === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      xl = s_xLeft; xr = s_xRight; yt = s_yTop; yb = s_yBottom;
      cnt = s_starCount; rx = s_rdX; ry = s_rdY;
      for (int y = int'(yt); y <= int'(yb); y++)
        for (int x = int'(xl); x <= int'(xr); x++) frame[y*SW + x] = '0;
      @(negedge clk);
      if (poke) s_goFind = 1'b1;
      @(negedge clk);
      s_goFind    = 1'b0;
      s_doneClean = 1'b1;
      @(negedge clk);
      s_doneClean = 1'b0;
    end
  endtask

  task automatic wait_done_small(output bit seen);
    int n;
    n = 0;
    seen = (s_doneFind === 1'b1);
    while (!seen && n < 5000) begin
      @(negedge clk);
      n++;
      seen = (s_doneFind === 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (s_rdX !== 0 || s_rdY !== 0) begin errors++; $display("FAIL reset_rd: got %0d,%0d want 0,0", s_rdX, s_rdY); end
    checks++; if ({s_xLeft, s_xRight, s_yTop, s_yBottom} !== '0) begin errors++; $display("FAIL reset_box: got %0d %0d %0d %0d want 0 0 0 0", s_xLeft, s_xRight, s_yTop, s_yBottom); end
    checks++; if (s_goClean !== 1'b0 || s_doneFind !== 1'b0) begin errors++; $display("FAIL reset_pulses: got goClean=%b doneFind=%b want 0 0", s_goClean, s_doneFind); end
    checks++; if (s_busy !== 1'b0 || s_starCount !== 0) begin errors++; $display("FAIL reset_busy_cnt: got busy=%b cnt=%0d want 0 0", s_busy, s_starCount); end
    checks++; if (s_dbgState !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", s_dbgState, IDLE); end
    checks++; if ({b_rdX, b_rdY, b_xLeft, b_xRight, b_yTop, b_yBottom, b_goClean, b_doneFind, b_busy, b_starCount} !== '0) begin errors++; $display("FAIL reset_big: got rd=%0d,%0d busy=%b cnt=%0d want all zero", b_rdX, b_rdY, b_busy, b_starCount); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty_frame();
    int k;
    int gc0;
    gc0 = b_gc_cnt;
    b_goFind = 1'b1;
    @(negedge clk);
    b_goFind = 1'b0;
    k = 1;
    checks++; if (b_rdX !== 0 || b_rdY !== 0 || b_busy !== 1'b1) begin errors++; $display("FAIL empty_start: got rd=%0d,%0d busy=%b want 0,0 1", b_rdX, b_rdY, b_busy); end
    while (b_doneFind !== 1'b1 && k < 40000) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 38401) begin errors++; $display("FAIL empty_latency: got %0d want 38401", k); end
    checks++; if (b_gc_cnt - gc0 !== 0) begin errors++; $display("FAIL empty_goclean: got %0d pulses want 0", b_gc_cnt - gc0); end
    checks++; if (b_starCount !== 0) begin errors++; $display("FAIL empty_count: got %0d want 0", b_starCount); end
    @(negedge clk);
    checks++; if (b_doneFind !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL empty_end: got doneFind=%b busy=%b want 0 0", b_doneFind, b_busy); end
  endtask

  task automatic test_single_blob();
    logic [xSz-1:0] xl, xr, rx; logic [ySz-1:0] yt, yb, ry; logic [cntSz-1:0] cnt; bit ok, seen; int gc0;
    clear_frame();
    set_rect(10, 12, 20, 22);
    gc0 = s_gc_cnt;
    pulse_go_small();
    serve_clean(1'b1, xl, xr, yt, yb, cnt, rx, ry, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL blob_goclean_seen: got %b want 1", ok); end
    checks++; if ({xl, xr, yt, yb} !== {8'd8, 8'd14, 7'd18, 7'd24}) begin errors++; $display("FAIL blob_box: got %0d %0d %0d %0d want 8 14 18 24", xl, xr, yt, yb); end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL blob_cnt_at_clean: got %0d want 1", cnt); end
    checks++; if (s_dbgState !== SCAN_RD || s_rdX !== 11 || s_rdY !== 20) begin errors++; $display("FAIL blob_resume: got st=%0d rd=%0d,%0d want %0d 11,20", s_dbgState, s_rdX, s_rdY, SCAN_RD); end
    checks++; if (s_starCount !== 1) begin errors++; $display("FAIL blob_gofind_ignored: got cnt %0d want 1", s_starCount); end
    wait_done_small(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL blob_donefind: got %b want 1", seen); end
    checks++; if (s_starCount !== 1 || s_gc_cnt - gc0 !== 1) begin errors++; $display("FAIL blob_totals: got cnt=%0d pulses=%0d want 1 1", s_starCount, s_gc_cnt - gc0); end
    checks++; if ({s_xLeft, s_xRight, s_yTop, s_yBottom} !== {8'd8, 8'd14, 7'd18, 7'd24}) begin errors++; $display("FAIL blob_box_hold: got %0d %0d %0d %0d want 8 14 18 24", s_xLeft, s_xRight, s_yTop, s_yBottom); end
    @(negedge clk);
    checks++; if (s_busy !== 1'b0 || s_doneFind !== 1'b0) begin errors++; $display("FAIL blob_idle: got busy=%b doneFind=%b want 0 0", s_busy, s_doneFind); end
  endtask

  task automatic test_clamp(input int x0, input int x1, input int y0, input int y1,
                            input logic [xSz-1:0] exl, input logic [xSz-1:0] exr,
                            input logic [ySz-1:0] eyt, input logic [ySz-1:0] eyb);
    logic [xSz-1:0] xl, xr, rx; logic [ySz-1:0] yt, yb, ry; logic [cntSz-1:0] cnt; bit ok, seen;
    clear_frame();
    set_rect(x0, x1, y0, y1);
    pulse_go_small();
    serve_clean(1'b0, xl, xr, yt, yb, cnt, rx, ry, ok);
    checks++; if ({xl, xr, yt, yb} !== {exl, exr, eyt, eyb} || ok !== 1'b1) begin errors++; $display("FAIL clamp_box: got %0d %0d %0d %0d (seen %b) want %0d %0d %0d %0d", xl, xr, yt, yb, ok, exl, exr, eyt, eyb); end
    wait_done_small(seen);
    checks++; if (seen !== 1'b1 || s_starCount !== 1) begin errors++; $display("FAIL clamp_done: got done=%b cnt=%0d want 1 1", seen, s_starCount); end
  endtask

  task automatic test_corner_pixel();
    logic [xSz-1:0] xl, xr, rx; logic [ySz-1:0] yt, yb, ry; logic [cntSz-1:0] cnt; bit ok;
    clear_frame();
    set_rect(SXMAX, SXMAX, SYMAX, SYMAX);
    pulse_go_small();
    serve_clean(1'b0, xl, xr, yt, yb, cnt, rx, ry, ok);
    checks++; if ({xl, xr, yt, yb} !== {8'd37, 8'd39, 7'd27, 7'd29} || ok !== 1'b1) begin errors++; $display("FAIL corner_box: got %0d %0d %0d %0d want 37 39 27 29", xl, xr, yt, yb); end
    checks++; if (s_doneFind !== 1'b1 || s_starCount !== 1) begin errors++; $display("FAIL corner_direct_done: got doneFind=%b cnt=%0d want 1 1", s_doneFind, s_starCount); end
    checks++; if (s_rdX !== rx || s_rdY !== ry) begin errors++; $display("FAIL corner_no_reads: got %0d,%0d want %0d,%0d", s_rdX, s_rdY, rx, ry); end
    @(negedge clk);
    checks++; if (s_busy !== 1'b0 || s_doneFind !== 1'b0) begin errors++; $display("FAIL corner_idle: got busy=%b doneFind=%b want 0 0", s_busy, s_doneFind); end
  endtask

  task automatic test_two_stars();
    logic [xSz-1:0] xl, xr, rx; logic [ySz-1:0] yt, yb, ry; logic [cntSz-1:0] cnt; bit ok, seen; int gc0;
    clear_frame();
    set_rect(5, 5, 5, 5);
    set_rect(30, 30, 25, 25);
    gc0 = s_gc_cnt;
    pulse_go_small();
    serve_clean(1'b0, xl, xr, yt, yb, cnt, rx, ry, ok);
    checks++; if ({xl, xr, yt, yb} !== {8'd3, 8'd7, 7'd3, 7'd7} || cnt !== 1) begin errors++; $display("FAIL two_first: got %0d %0d %0d %0d cnt=%0d want 3 7 3 7 cnt=1", xl, xr, yt, yb, cnt); end
    serve_clean(1'b0, xl, xr, yt, yb, cnt, rx, ry, ok);
    checks++; if ({xl, xr, yt, yb} !== {8'd28, 8'd32, 7'd23, 7'd27} || cnt !== 2) begin errors++; $display("FAIL two_second: got %0d %0d %0d %0d cnt=%0d want 28 32 23 27 cnt=2", xl, xr, yt, yb, cnt); end
    wait_done_small(seen);
    checks++; if (seen !== 1'b1 || s_starCount !== 2 || s_gc_cnt - gc0 !== 2) begin errors++; $display("FAIL two_totals: got done=%b cnt=%0d pulses=%0d want 1 2 2", seen, s_starCount, s_gc_cnt - gc0); end
  endtask

  task automatic test_reset_mid_runx();
    bit found; int gc0;
    clear_frame();
    set_rect(10, 12, 20, 22);
    pulse_go_small();
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (s_dbgState === RUNX_CHK) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_reach_runx: got %b want 1", found); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({s_rdX, s_rdY, s_xLeft, s_xRight, s_yTop, s_yBottom, s_goClean, s_doneFind, s_busy, s_starCount} !== '0) begin errors++; $display("FAIL rst_outputs: got rd=%0d,%0d busy=%b cnt=%0d goClean=%b want all zero", s_rdX, s_rdY, s_busy, s_starCount, s_goClean); end
    reset = 1'b0;
    gc0 = s_gc_cnt;
    s_doneClean = 1'b1;
    @(negedge clk);
    s_doneClean = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (s_gc_cnt - gc0 !== 0 || s_busy !== 1'b0 || s_dbgState !== IDLE) begin errors++; $display("FAIL rst_stays_idle: got pulses=%0d busy=%b st=%0d want 0 0 %0d", s_gc_cnt - gc0, s_busy, s_dbgState, IDLE); end
  endtask

  initial begin
    reset = 1'b1;
    b_goFind = 1'b0; b_doneClean = 1'b0; b_pixIn = '0;
    s_goFind = 1'b0; s_doneClean = 1'b0;
    clear_frame();
    test_reset();
    test_empty_frame();
    test_single_blob();
    test_clamp(0, 1, 0, 1, 8'd0, 8'd3, 7'd0, 7'd3);
    test_clamp(SXMAX-1, SXMAX, SYMAX-1, SYMAX, 8'd36, 8'd39, 7'd26, 7'd29);
    test_corner_pixel();
    test_two_stars();
    test_reset_mid_runx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
